dff2_checker: RTL and testbench
===============================

# dff2_checker

Synthesizable in-line checker for the two-output reset flop (`dff2`). It is the receiving end of the flop's stimulus. Each cycle it observes the flop's applied `reset`/`d` and its `q`/`qb` outputs, and keeps a one-cycle reference model. It counts compares and mismatches, captures the first failure, and reports sticky pass/fail status. This lets both simulation benches and on-chip self-test use one scoreboard instead of reading `$monitor` logs.

## Interface
Parameters:
- `WIDTH`, default 1: data width of the observed flop.
- `CNT_W`, default 16: width of all counters.

Ports:
- `clk`, in, 1: clock; same clock as the observed flop.
- `reset`, in, 1: synchronous, active-high reset of the checker itself.
- `en`, in, 1: checking enable; level-sensitive.
- `clear`, in, 1: zeroes counters and status; one-cycle pulse.
- `obs_reset`, in, 1: reset as applied to the observed flop.
- `obs_d`, in, WIDTH: `d` as applied to the observed flop.
- `obs_q`, in, WIDTH: observed `q`.
- `obs_qb`, in, WIDTH: observed `qb`.
- `pass`, out, 1: checking active and no mismatch seen.
- `fail`, out, 1: at least one mismatch seen; sticky.
- `cyc_count`, out, CNT_W: number of compares performed; saturating.
- `err_count`, out, CNT_W: number of mismatching compares; saturating.
- `first_err_cycle`, out, CNT_W: `cyc_count` index of the first mismatch.
- `first_err_q`, out, WIDTH: `obs_q` captured at the first mismatch.

## Operation
- Reference model, updated at every edge while not IDLE: `exp_q <= obs_reset ? 0 : obs_d`.
- Compare: `obs_q == exp_q` and `obs_qb == ~exp_q`, all bits. Either term false is a mismatch.
- Comparison is 2-state. Inputs are not checked before PRIME completes, so X on `obs_d` before the first model load is harmless.
- States:
  - IDLE: no compares, counters hold. `en`=1 goes to PRIME.
  - PRIME: loads `exp_q` for one cycle, no compare. Goes to CHECK.
  - CHECK: compares every cycle and increments `cyc_count`. A mismatch increments `err_count`, latches `first_err_cycle` (the pre-increment `cyc_count`) and `first_err_q`, and goes to FAIL.
  - FAIL: keeps comparing, counting and updating `exp_q`. First-error fields are frozen.
- From any state, `en`=0 goes to IDLE. All counters and status hold, so results stay readable.
- Re-asserting `en` from IDLE goes to PRIME again. Counters continue from their held values; `fail` stays set.
- Priority: `reset` > `clear` > `en`. `clear` zeroes all counters and first-error fields, clears `fail` and goes to IDLE, regardless of `en`. If `en` is still 1, PRIME follows on the next cycle.
- Saturation: counters stop at 2^CNT_W−1 and never wrap. `fail` remains set once set.
- `obs_reset` asserted mid-run is ordinary stimulus. It forces `exp_q`=0 and is not an error source.

## Timing
- Reset values:
  - `pass`=0, `fail`=0.
  - `cyc_count`=0, `err_count`=0.
  - `first_err_cycle`=0, `first_err_q`=0.
  - state=IDLE, `exp_q`=0.
- All outputs are registered; no combinational path from input to output.
- Model latency:
  - Inputs sampled at edge k load `exp_q`.
  - `obs_q`/`obs_qb` sampled at edge k+1 are compared against it.
  - The result is visible on the outputs after edge k+1.
- `en` rising at edge n: PRIME at n, first compare at n+1, `cyc_count`=1 after n+1.
- `pass` = (state==CHECK) && !`fail`. It drops in the same cycle `fail` rises.
- A mismatch on the same edge as `en` falling is discarded. The IDLE transition wins.

## Structure
- Package `dff2_checker_pkg` holds:
  - the state enum (IDLE, PRIME, CHECK, FAIL);
  - the default `CNT_W` constant.
- Sub-module `sat_counter`, parameterized by width, with inputs inc, clr and output count. It is instantiated for `cyc_count` and `err_count`.
- The FSM, reference register and first-error capture stay in the top module.

## Test plan
- Reset and idle: assert `reset` 3 cycles, hold `en`=0 → all outputs 0 and stay 0 for 10 cycles with `obs_q` toggling.
- Clean run: connect a correct `dff2` model, assert `en`, drive `obs_reset`=1 for 4 cycles, then `obs_d` sequence 1,0,1,1,0 → `pass`=1, `fail`=0, `cyc_count`=9, `err_count`=0.
- Injected fault: force `obs_q` inverted on compare index 5 only → `fail` rises after that edge, `pass` falls, `first_err_cycle`=5, `err_count`=1 thereafter.
- qb fault: `obs_q` correct but `obs_qb`=`obs_q` for 3 cycles → `err_count`=3, `first_err_q` equals correct `exp_q`.
- Clear and re-arm: after a failure, pulse `clear` with `en`=1 → the next cycle shows all counters 0 and `fail`=0. PRIME then CHECK follow, and `pass`=1 after the first clean compare.
- Saturation: `CNT_W`=3 with a permanently stuck `obs_q` for 12 cycles → `cyc_count`=7, `err_count`=7, no wrap, `first_err_cycle`=0.

Source files
------------

// File: rtl/dff2_checker_pkg.sv
// Shared types and constants for the dff2 in-line checker.
package dff2_checker_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_CHECK,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/dff2_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dff2_checker.sv
// In-line scoreboard for the two-output reset flop: one-cycle
// reference model, compare counters and first-failure capture.
module dff2_checker
  import dff2_checker_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             obs_reset,
  input  logic [WIDTH-1:0] obs_d,
  input  logic [WIDTH-1:0] obs_q,
  input  logic [WIDTH-1:0] obs_qb,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [WIDTH-1:0] first_err_q
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               fail_q, fail_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   fec_q, fec_d;
  logic [WIDTH-1:0]   feq_q, feq_d;
  logic               cmp;
  logic               mism;

  assign mism = (obs_q != exp_q) || (obs_qb != ~exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    fail_d  = fail_q;
    fec_d   = fec_q;
    feq_d   = feq_q;
    cmp     = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      fail_d  = 1'b0;
      fec_d   = '0;
      feq_d   = '0;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else begin
      exp_d = obs_reset ? '0 : obs_d;
      unique case (state_q)
        ST_IDLE: state_d = ST_PRIME;
        ST_PRIME, ST_CHECK, ST_FAIL: begin
          cmp     = 1'b1;
          state_d = (mism || fail_q) ? ST_FAIL : ST_CHECK;
          // only the first mismatch since reset/clear is captured
          if (mism && !fail_q) begin
            fail_d = 1'b1;
            fec_d  = cyc_count;
            feq_d  = obs_q;
          end
        end
      endcase
    end
    pass_d = (state_d == ST_CHECK) && !fail_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      fail_q  <= 1'b0;
      pass_q  <= 1'b0;
      fec_q   <= '0;
      feq_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      fec_q   <= fec_d;
      feq_q   <= feq_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk   (clk),
    .reset (reset),
    .inc   (cmp),
    .clr   (clear),
    .count (cyc_count)
  );

  sat_counter #(.W(CNT_W)) u_err (
    .clk   (clk),
    .reset (reset),
    .inc   (cmp && mism),
    .clr   (clear),
    .count (err_count)
  );

  assign pass            = pass_q;
  assign fail            = fail_q;
  assign first_err_cycle = fec_q;
  assign first_err_q     = feq_q;

endmodule

// File: tb/tb_dff2_checker.sv
// Directed bench for dff2_checker: behavioural dff2 plus fault
// injection on q/qb, and a narrow-counter instance for saturation.
module tb_dff2_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, clear, en_s;
  logic        obs_reset, obs_d, inj_q, inj_qb, dq;
  logic        obs_q, obs_qb;
  logic        pass, fail, feq;
  logic [15:0] cyc, err, fec;
  logic        pass_s, fail_s, feq_s;
  logic [2:0]  cyc_s, err_s, fec_s;
  logic [4:0]  dv;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) dq <= obs_reset ? 1'b0 : obs_d;
  assign obs_q  = dq ^ inj_q;
  assign obs_qb = ~dq ^ inj_qb;

  dff2_checker #(.WIDTH(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .obs_reset(obs_reset), .obs_d(obs_d),
    .obs_q(obs_q), .obs_qb(obs_qb),
    .pass(pass), .fail(fail),
    .cyc_count(cyc), .err_count(err),
    .first_err_cycle(fec), .first_err_q(feq)
  );

  dff2_checker #(.WIDTH(1), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .en(en_s), .clear(clear),
    .obs_reset(1'b0), .obs_d(1'b0),
    .obs_q(1'b1), .obs_qb(1'b0),
    .pass(pass_s), .fail(fail_s),
    .cyc_count(cyc_s), .err_count(err_s),
    .first_err_cycle(fec_s), .first_err_q(feq_s)
  );

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clear = 1'b0; en_s = 1'b0;
    obs_reset = 1'b0; obs_d = 1'b0; inj_q = 1'b0; inj_qb = 1'b0;
    repeat (3) tick();
    check_eq("rst_flags", {62'd0, pass, fail}, 64'd0);
    check_eq("rst_cyc", 64'(cyc), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_fec", 64'(fec), 64'd0);
    check_eq("rst_feq", 64'(feq), 64'd0);
    check_eq("rst_sat", {58'd0, cyc_s, err_s}, 64'd0);

    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      obs_d = i[0];
      tick();
      check_eq("idle", {30'd0, pass, fail, cyc, err}, 64'd0);
    end

    // clean run: obs_reset 4 cycles, then d = 1,0,1,1,0
    dv = 5'b01101;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      obs_reset = (i < 4);
      obs_d = (i < 4) ? 1'b1 : (i < 9) ? dv[i-4] : 1'b0;
      tick();
      if (i == 0) check_eq("prime", {47'd0, pass, cyc}, 64'd0);
      if (i == 1) check_eq("first_cmp", {47'd0, pass, cyc}, {47'd1, 16'd1});
    end
    check_eq("clean_pf", {62'd0, pass, fail}, 64'd2);
    check_eq("clean_cyc", 64'(cyc), 64'd9);
    check_eq("clean_err", 64'(err), 64'd0);

    // injected q fault on compare index 5
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_cyc", 64'(cyc), 64'd0);
    for (int j = 1; j <= 9; j++) begin
      obs_d = j[0];
      inj_q = (j == 7);
      tick();
      if (j == 6) check_eq("pre_fault", {62'd0, pass, fail}, 64'd2);
      if (j == 7) begin
        check_eq("fault_pf", {62'd0, pass, fail}, 64'd1);
        check_eq("fault_fec", 64'(fec), 64'd5);
        check_eq("fault_feq", 64'(feq), 64'd1);
        check_eq("fault_err", 64'(err), 64'd1);
      end
    end
    inj_q = 1'b0;
    check_eq("post_err", 64'(err), 64'd1);
    check_eq("post_cyc", 64'(cyc), 64'd8);
    check_eq("post_fec", 64'(fec), 64'd5);

    // qb fault for three compares (indices 2..4)
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      obs_d = j[0];
      inj_qb = (j >= 4 && j <= 6);
      tick();
    end
    inj_qb = 1'b0;
    check_eq("qb_err", 64'(err), 64'd3);
    check_eq("qb_feq", 64'(feq), 64'd1);
    check_eq("qb_fec", 64'(fec), 64'd2);
    check_eq("qb_fail", 64'(fail), 64'd1);

    // clear and re-arm after a failure, en held high
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("rearm_flags", {62'd0, pass, fail}, 64'd0);
    check_eq("rearm_cnt", {32'd0, cyc, err}, 64'd0);
    check_eq("rearm_fe", {47'd0, fec, feq}, 64'd0);
    tick();
    check_eq("rearm_prime", 64'(pass), 64'd0);
    tick();
    check_eq("rearm_pass", {46'd0, pass, fail, cyc}, {46'd2, 16'd1});

    // mismatch on the en-falling edge is discarded
    en = 1'b0;
    inj_q = 1'b1;
    tick();
    check_eq("endrop", {30'd0, pass, fail, cyc, err}, {32'd0, 16'd1, 16'd0});
    inj_q = 1'b0;
    en = 1'b1;
    tick();
    tick();
    check_eq("reen", {47'd0, pass, cyc}, {47'd1, 16'd2});
    en = 1'b0;

    // saturation on the 3-bit instance
    en_s = 1'b1;
    repeat (13) tick();
    check_eq("sat_cyc", 64'(cyc_s), 64'd7);
    check_eq("sat_err", 64'(err_s), 64'd7);
    check_eq("sat_fec", 64'(fec_s), 64'd0);
    check_eq("sat_flags", {61'd0, pass_s, fail_s, feq_s}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
